fetch_stage: RTL

- IF stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Sits directly upstream of the hazard/forwarding unit and the ID stage:
  - consumes stallFE, stallID and the ID-stage branch/jump redirect;
  - produces the instruction, PC+4 and a valid bit that ID decodes into rsID/rtID/branchID.
- Handles instruction-memory not-ready cycles and a debug-step enable.
- Keeps a retired-fetch counter for the debug unit.

---
 rtl/mips_defs.sv | 12 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 70 +++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS core definitions: data width, PC increment and reset/bubble constants.
package mips_defs;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] wordT;

   localparam wordT PC_INC    = 32'd4;
   localparam wordT NOP_INSTR = 32'h0000_0000;
   localparam wordT RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold on stallID, flush on redirect, bubble on fetch miss, else load.
module if_id_reg
   import mips_defs::*;
#(
   parameter wordT NOP = NOP_INSTR
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic stallID,
   input  logic pcSrcID,
   input  logic fetchOk,
   input  wordT instrFE,
   input  wordT pcPlus4FE,
   output wordT instrID,
   output wordT pcPlus4ID,
   output logic validID,
   output logic loadValid
);

   // A real instruction enters ID only when nothing stalls, flushes or misses.
   assign loadValid = enable & ~stallID & ~pcSrcID & fetchOk;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instrID   <= NOP;
         pcPlus4ID <= '0;
         validID   <= 1'b0;
      end else if (enable && !stallID) begin
         if (loadValid) begin
            instrID   <= instrFE;
            pcPlus4ID <= pcPlus4FE;
            validID   <= 1'b1;
         end else begin
            // Flush and bubble look the same to ID; pcPlus4ID keeps its last value.
            instrID <= NOP;
            validID <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS core: PC register, +4 adder, IF/ID register and retired-fetch counter.
module fetch_stage #(
   parameter mips_defs::wordT RESET_PC  = mips_defs::RESET_PC,
   parameter mips_defs::wordT NOP_INSTR = mips_defs::NOP_INSTR,
   parameter int              CNT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  stallFE,
   input  logic                  stallID,
   input  logic                  pcSrcID,
   input  logic [31:0]           pcTargetID,
   input  logic [31:0]           instrFE,
   input  logic                  instrReady,
   output logic [31:0]           pcFE,
   output logic [31:0]           instrID,
   output logic [31:0]           pcPlus4ID,
   output logic                  validID,
   output logic [CNT_WIDTH-1:0]  fetchCount
);

   mips_defs::wordT pcPlus4FE;
   logic            fetchOk;
   logic            loadValid;
   logic            redirect;

   assign pcPlus4FE = pcFE + mips_defs::PC_INC;
   assign fetchOk   = ~stallFE & instrReady;
   // A redirect is only trusted once ID has real branch operands, i.e. ID is not stalled.
   assign redirect  = pcSrcID & ~stallID;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcFE <= RESET_PC;
      end else if (enable) begin
         if (redirect) begin
            pcFE <= pcTargetID;
         end else if (fetchOk) begin
            pcFE <= pcPlus4FE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetchCount <= '0;
      end else if (loadValid) begin
         fetchCount <= fetchCount + CNT_WIDTH'(1);
      end
   end

   if_id_reg #(
      .NOP (NOP_INSTR)
   ) uIfId (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .stallID   (stallID),
      .pcSrcID   (pcSrcID),
      .fetchOk   (fetchOk),
      .instrFE   (instrFE),
      .pcPlus4FE (pcPlus4FE),
      .instrID   (instrID),
      .pcPlus4ID (pcPlus4ID),
      .validID   (validID),
      .loadValid (loadValid)
   );

endmodule
